// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : meas_pkg
// Brief    : Frame tags, field positions, command opcodes and TX FSM states
//            shared by the measurement framing interface.
// Revision : 1.0 - initial release
// ============================================================================
package meas_pkg;

    localparam logic [2:0] C_TAG_DATA   = 3'b101;
    localparam logic [2:0] C_TAG_STATUS = 3'b010;

    localparam int C_FR_OVF_BIT = 18;

    localparam logic [7:0] C_OP_NOP   = 8'h00;
    localparam logic [7:0] C_OP_START = 8'h01;
    localparam logic [7:0] C_OP_MODE  = 8'h02;
    localparam logic [7:0] C_OP_CLEAR = 8'h03;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } tx_state_t;

endpackage : meas_pkg
`default_nettype wire

// File: rtl/meas_frame_if_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : frame_fifo
// Brief    : Synchronous frame FIFO with flush, registered level/full/empty
//            and simultaneous push/pop (push accepted on full when popping).
// Revision : 1.0 - initial release
// ============================================================================
module frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_not_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             r_not_empty;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop && r_not_empty && !i_flush;
    assign w_push_ok = i_push && (!r_full || w_pop_ok) && !i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + 1'b1;
                if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == (AW+1)'(DEPTH));
            r_not_empty <= (w_count_nxt != '0);
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_data;
    end

    assign o_head      = r_mem[r_rptr];
    assign o_full      = r_full;
    assign o_not_empty = r_not_empty;
    assign o_level     = r_count;

endmodule : frame_fifo
`default_nettype wire

// File: rtl/meas_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : meas_frame_if
// Brief    : Frames conversion results into a FIFO, serves them to the SPI
//            slave write port and decodes received SPI command words.
// Revision : 1.0 - initial release
// ============================================================================
module meas_frame_if
    import meas_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     meas_done_i,
    input  logic [CNT_W-1:0]         count_i,
    input  logic [2:0]               range_sel_i,
    input  logic                     ref_sign_i,
    input  logic                     range_error_i,
    input  logic                     sat_hi_i,
    input  logic                     sat_lo_i,
    input  logic                     di_req_i,
    output logic [31:0]              di_o,
    output logic                     wren_o,
    input  logic                     wr_ack_i,
    input  logic                     do_valid_i,
    input  logic [31:0]              do_i,
    output logic                     meas_start_o,
    output logic [1:0]               mode_sel_o,
    output logic                     irq_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [2:0]  r_seq;
    logic        r_cmd_err;
    logic        r_is_data;
    logic        r_overflow;
    logic [1:0]  r_mode;
    logic        r_start;
    logic [31:0] r_di;
    logic        r_wren;

    logic [7:0]  w_opcode;
    logic        w_clear;
    logic        w_ack;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_latch;
    logic        w_full;
    logic        w_not_empty;
    logic [31:0] w_head;
    logic [31:0] w_head_ovf;
    logic [31:0] w_frame;
    logic [31:0] w_status;
    logic [15:0] w_count16;
    logic        w_unused;

    assign w_opcode  = do_i[31:24];
    assign w_clear   = do_valid_i && (w_opcode == C_OP_CLEAR);
    assign w_ack     = (r_state == ST_WRITE) && wr_ack_i;
    assign w_pop     = w_ack && r_is_data;
    assign w_push    = meas_done_i && !w_clear && (!w_full || w_pop);
    assign w_drop    = meas_done_i && !w_clear && w_full && !w_pop;
    assign w_latch   = (r_state == ST_IDLE) && di_req_i;
    assign w_count16 = 16'(count_i);
    assign w_unused  = ^do_i[23:2];

    assign w_frame  = {C_TAG_DATA, r_seq, ref_sign_i, range_sel_i, range_error_i,
                       sat_hi_i, sat_lo_i, 1'b0, 2'b00, w_count16};
    assign w_status = {C_TAG_STATUS, r_mode, r_cmd_err, r_overflow, 25'd0};

    // The overflow flag is inserted when a frame is served, not when stored,
    // so every frame still queued reports a drop that happened behind it.
    always_comb begin
        w_head_ovf               = w_head;
        w_head_ovf[C_FR_OVF_BIT] = r_overflow;
    end

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .i_push      (w_push),
        .i_data      (w_frame),
        .i_pop       (w_pop),
        .i_flush     (w_clear),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_not_empty (w_not_empty),
        .o_level     (level_o)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (di_req_i) w_state_nxt = ST_WRITE;
            ST_WRITE: if (wr_ack_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_di      <= '0;
            r_wren    <= 1'b0;
            r_is_data <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wren  <= (w_state_nxt == ST_WRITE);
            if (w_latch) begin
                r_di      <= w_not_empty ? w_head_ovf : w_status;
                r_is_data <= w_not_empty;
            end
            // A flush invalidates the word in flight, so its pop is cancelled.
            if (w_clear) r_is_data <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq      <= '0;
            r_cmd_err  <= 1'b0;
            r_overflow <= 1'b0;
            r_mode     <= 2'b00;
            r_start    <= 1'b0;
        end else begin
            r_start <= do_valid_i && (w_opcode == C_OP_START);
            if (w_clear) begin
                r_seq      <= '0;
                r_cmd_err  <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_seq <= r_seq + 1'b1;
                if (w_drop) r_overflow <= 1'b1;
                if (do_valid_i) begin
                    case (w_opcode)
                        C_OP_NOP, C_OP_START: ;
                        C_OP_MODE: r_mode    <= do_i[1:0];
                        default:   r_cmd_err <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign di_o         = r_di;
    assign wren_o       = r_wren;
    assign meas_start_o = r_start;
    assign mode_sel_o   = r_mode;
    assign irq_o        = w_not_empty;
    assign overflow_o   = r_overflow;

endmodule : meas_frame_if
`default_nettype wire

// File: tb/tb_meas_frame_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_meas_frame_if
// Brief    : Directed self-checking bench for meas_frame_if.
// Revision : 1.0 - initial release
// ============================================================================
module tb_meas_frame_if;

    localparam int C_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_done = 1'b0;
    logic [15:0] count = '0;
    logic [2:0]  range_sel = '0;
    logic        ref_sign = 1'b0;
    logic        range_err = 1'b0;
    logic        sat_hi = 1'b0;
    logic        sat_lo = 1'b0;
    logic        di_req = 1'b0;
    logic [31:0] di;
    logic        wren;
    logic        wr_ack = 1'b0;
    logic        do_valid = 1'b0;
    logic [31:0] do_w = '0;
    logic        meas_start;
    logic [1:0]  mode_sel;
    logic        irq;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    meas_frame_if #(.CNT_W(16), .DEPTH(C_DEPTH)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .meas_done_i   (meas_done),
        .count_i       (count),
        .range_sel_i   (range_sel),
        .ref_sign_i    (ref_sign),
        .range_error_i (range_err),
        .sat_hi_i      (sat_hi),
        .sat_lo_i      (sat_lo),
        .di_req_i      (di_req),
        .di_o          (di),
        .wren_o        (wren),
        .wr_ack_i      (wr_ack),
        .do_valid_i    (do_valid),
        .do_i          (do_w),
        .meas_start_o  (meas_start),
        .mode_sel_o    (mode_sel),
        .irq_o         (irq),
        .level_o       (level),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    // Stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [15:0] c, input logic [2:0] r,
                              input logic rs, input logic re,
                              input logic hi, input logic lo);
        count = c; range_sel = r; ref_sign = rs; range_err = re;
        sat_hi = hi; sat_lo = lo; meas_done = 1'b1;
        step();
        meas_done = 1'b0;
    endtask

    task automatic do_req();
        di_req = 1'b1;
        step();
        di_req = 1'b0;
    endtask

    task automatic do_ack();
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] w);
        do_w = w; do_valid = 1'b1;
        step();
        do_valid = 1'b0; do_w = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({di, wren, meas_start, mode_sel, irq, level, overflow} !== 41'd0) begin
            failures++;
            $display("FAIL reset: di=%h wren=%b start=%b mode=%b irq=%b level=%0d ovf=%b, need all 0",
                     di, wren, meas_start, mode_sel, irq, level, overflow);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_status_idle();
        do_req();
        checks++;
        if (wren !== 1'b1 || di !== 32'h4000_0000) begin
            failures++;
            $display("FAIL status_idle: wren=%b di=%h, need 1 40000000", wren, di);
        end
        step();
        checks++;
        if (wren !== 1'b1 || di !== 32'h4000_0000) begin
            failures++;
            $display("FAIL status_hold: wren=%b di=%h, need 1 40000000", wren, di);
        end
        do_ack();
        checks++;
        if (wren !== 1'b0 || level !== 3'd0) begin
            failures++;
            $display("FAIL status_ack: wren=%b level=%0d, need 0 0", wren, level);
        end
    endtask

    task automatic test_single_frame();
        pulse_done(16'h1234, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (irq !== 1'b1 || level !== 3'd1) begin
            failures++;
            $display("FAIL single_push: irq=%b level=%0d, need 1 1", irq, level);
        end
        do_req();
        checks++;
        if (wren !== 1'b1 || di !== 32'hA340_1234) begin
            failures++;
            $display("FAIL single_frame: wren=%b di=%h, need 1 a3401234", wren, di);
        end
        do_ack();
        checks++;
        if (level !== 3'd0 || irq !== 1'b0 || wren !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: level=%0d irq=%b wren=%b, need 0 0 0", level, irq, wren);
        end
    endtask

    task automatic test_overflow();
        logic [2:0]  k3;
        logic [15:0] c;
        logic [31:0] exp;
        send_cmd(32'h0300_0000);
        for (int k = 0; k < 5; k++) begin
            k3 = 3'(k);
            pulse_done(16'h0100 + 16'(k), 3'd0, 1'b0, 1'b0, 1'b0, k3[0]);
        end
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_fill: level=%0d ovf=%b, need 4 1", level, overflow);
        end
        for (int k = 0; k < 4; k++) begin
            k3  = 3'(k);
            c   = 16'h0100 + 16'(k);
            exp = {3'b101, k3, 1'b0, 3'd0, 1'b0, 1'b0, k3[0], 1'b1, 2'b00, c};
            do_req();
            checks++;
            if (di !== exp) begin
                failures++;
                $display("FAIL overflow_drain%0d: di=%h, need %h", k, di, exp);
            end
            do_ack();
            checks++;
            if (level !== 3'(3 - k)) begin
                failures++;
                $display("FAIL overflow_level%0d: level=%0d, need %0d", k, level, 3 - k);
            end
        end
    endtask

    task automatic test_clear_during_write();
        send_cmd(32'h0300_0000);
        for (int k = 0; k < 5; k++) pulse_done(16'h0200 + 16'(k), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            do_req();
            do_ack();
        end
        checks++;
        if (level !== 3'd2 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL clr_setup: level=%0d ovf=%b, need 2 1", level, overflow);
        end
        do_req();
        checks++;
        if (di !== 32'hA804_0202) begin
            failures++;
            $display("FAIL clr_frame: di=%h, need a8040202", di);
        end
        send_cmd(32'h0300_0000);
        checks++;
        if (di !== 32'hA804_0202 || wren !== 1'b1 || level !== 3'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_hold: di=%h wren=%b level=%0d ovf=%b, need a8040202 1 0 0",
                     di, wren, level, overflow);
        end
        do_ack();
        checks++;
        if (level !== 3'd0 || wren !== 1'b0) begin
            failures++;
            $display("FAIL clr_after_ack: level=%0d wren=%b, need 0 0", level, wren);
        end
        pulse_done(16'h0300, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req();
        checks++;
        if (di !== 32'hA000_0300) begin
            failures++;
            $display("FAIL clr_seq0: di=%h, need a0000300", di);
        end
        do_ack();
    endtask

    task automatic test_commands();
        send_cmd(32'h0200_0003);
        checks++;
        if (mode_sel !== 2'b11 || meas_start !== 1'b0) begin
            failures++;
            $display("FAIL cmd_mode: mode=%b start=%b, need 11 0", mode_sel, meas_start);
        end
        send_cmd(32'h0100_0000);
        checks++;
        if (meas_start !== 1'b1) begin
            failures++;
            $display("FAIL cmd_start: start=%b, need 1", meas_start);
        end
        step();
        checks++;
        if (meas_start !== 1'b0) begin
            failures++;
            $display("FAIL cmd_start_pulse: start=%b, need 0", meas_start);
        end
        send_cmd(32'h7F00_0000);
        do_req();
        checks++;
        if (di !== 32'h5C00_0000) begin
            failures++;
            $display("FAIL cmd_err_status: di=%h, need 5c000000", di);
        end
        do_ack();
        send_cmd(32'h0300_0000);
        do_req();
        checks++;
        if (di !== 32'h5800_0000) begin
            failures++;
            $display("FAIL cmd_err_cleared: di=%h, need 58000000", di);
        end
        do_ack();
    endtask

    task automatic test_push_pop_full();
        send_cmd(32'h0300_0000);
        for (int k = 0; k < 4; k++) pulse_done(16'h0400 + 16'(k), 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req();
        count = 16'h0404; meas_done = 1'b1; wr_ack = 1'b1;
        step();
        meas_done = 1'b0; wr_ack = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_full: level=%0d ovf=%b, need 4 0", level, overflow);
        end
        do_req();
        checks++;
        if (di !== 32'hA400_0401) begin
            failures++;
            $display("FAIL push_pop_next: di=%h, need a4000401", di);
        end
    endtask

    task automatic test_reset_mid_transfer();
        checks++;
        if (wren !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: wren=%b, need 1", wren);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wren !== 1'b0 || level !== 3'd0 || di !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid: wren=%b level=%0d di=%h, need 0 0 0", wren, level, di);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_status_idle();
        test_single_frame();
        test_overflow();
        test_clear_during_write();
        test_commands();
        test_push_pop_full();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_meas_frame_if
`default_nettype wire

// File: doc/meas_frame_if.md
# meas_frame_if

Measurement framing and command interface between the conversion `state_machine`/`counter` pair and the 32-bit `spi_slave`. Each completed conversion is captured as a tagged 32-bit result frame into a small FIFO. Frames are served to the SPI slave's parallel write port on `di_req` using the `wren`/`wr_ack` handshake. Received SPI words are decoded into start, mode and clear commands.

## Interface

- `CNT_W`, 16: width of the counter result field (fixed 16 in frame layout).
- `DEPTH`, 4: result FIFO depth in frames; power of two, 2..16.

- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `meas_done_i`  in  1  one-cycle pulse from state machine: result valid.
- `count_i`  in  CNT_W  counter value, sampled on `meas_done_i`.
- `range_sel_i`  in  3  active range, sampled on `meas_done_i`.
- `ref_sign_i`  in  1  reference sign, sampled on `meas_done_i`.
- `range_error_i`  in  1  range error, sampled on `meas_done_i`.
- `sat_hi_i`, `sat_lo_i`  in  1 each  sanitized saturation flags, sampled on `meas_done_i`.
- `di_req_i`  in  1  SPI slave requests next TX word (pulse).
- `di_o`  out  32  TX word to SPI slave.
- `wren_o`  out  1  TX word valid; held until `wr_ack_i`.
- `wr_ack_i`  in  1  SPI slave accepted `di_o`.
- `do_valid_i`  in  1  received word valid (pulse).
- `do_i`  in  32  received word.
- `meas_start_o`  out  1  one-cycle start pulse to state machine.
- `mode_sel_o`  out  2  measurement mode to state machine.
- `irq_o`  out  1  FIFO non-empty.
- `level_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow_o`  out  1  sticky: frame dropped on full FIFO.

## Operation

- Data frame: [31:29]=3'b101, [28:26]=seq, [25]=ref_sign, [24:22]=range, [21]=range_err, [20]=sat_hi, [19]=sat_lo, [18]=overflow_o, [17:16]=0, [15:0]=count.
- Status frame (FIFO empty): [31:29]=3'b010, [28:27]=mode_sel_o, [26]=cmd_err, [25]=overflow_o, [24:0]=0.
- `seq` is 3-bit, increments per pushed frame, wraps 7->0; dropped frames do not increment it.
- Push on `meas_done_i`. When full: drop the frame, set `overflow_o`.
- TX FSM, states IDLE, WRITE:
  - IDLE + `di_req_i` -> WRITE. Latch `di_o` = FIFO head if non-empty, else status frame. Record `is_data`.
  - WRITE: `wren_o`=1, `di_o` stable.
  - WRITE + `wr_ack_i` -> IDLE. Pop if `is_data`.
  - `di_req_i` in WRITE is ignored.
- Commands on `do_valid_i`, opcode `do_i[31:24]`:
  - 8'h01 START: pulse `meas_start_o`.
  - 8'h02 MODE: `mode_sel_o` <= `do_i[1:0]`.
  - 8'h03 CLEAR: flush FIFO; clear `overflow_o`, `cmd_err`, `seq`.
  - 8'h00: NOP.
  - Other opcodes: set sticky `cmd_err`.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, level unchanged; push is accepted even when full.
  - CLEAR with push: CLEAR wins, frame discarded.
  - CLEAR during WRITE: `wren_o`/`di_o` held until ack; the pop after ack is suppressed.
- Reset values:
  - `di_o`=0, `wren_o`=0, `meas_start_o`=0, `mode_sel_o`=2'b00, `irq_o`=0, `level_o`=0, `overflow_o`=0.
  - FSM=IDLE, `seq`=0, `cmd_err`=0.
- Reset asserted mid-transfer drops `wren_o` immediately (asynchronous).

## Timing

- `meas_done_i` at cycle N -> `level_o` and `irq_o` updated at N+1.
- `di_req_i` at N -> `wren_o`=1 and `di_o` valid at N+1.
- `wr_ack_i` at M -> `wren_o`=0 and pop visible on `level_o` at M+1. Earliest next `di_req_i` acceptance is M+1.
- `do_valid_i` at N -> `meas_start_o` pulse / `mode_sel_o` / clear effect at N+1.
- All outputs registered; no combinational path from any input to any output.

## Structure

- Shared package `meas_pkg`: frame tag constants, opcode constants, field bit positions, TX FSM state enum.
- One sub-module `frame_fifo` (parameterized sync FIFO with flush, full/empty, level, simultaneous push/pop). The TX FSM and command decoder stay in the top.

## Test plan

- Reset, then `di_req_i` -> `wren_o` at next cycle, `di_o`=32'h4000_0000; after `wr_ack_i`, `level_o` stays 0.
- `meas_done_i` with count=16'h1234, range=3'd5, ref_sign=1, others 0 -> `irq_o`=1; next served `di_o`=32'hA340_1234; after ack `level_o`=0, `irq_o`=0.
- Five `meas_done_i` pulses with DEPTH=4 -> `level_o`=4, `overflow_o`=1. Drained frames carry seq 0..3 and bit18=1 in all four.
- `do_i`=32'h0200_0003 then 32'h0100_0000 -> `mode_sel_o`=2'b11, then one-cycle `meas_start_o`. `do_i`=32'h7F00_0000 -> status frame bit26=1.
- CLEAR issued during WRITE of a data frame with `level_o`=2 -> `di_o` unchanged until ack; after ack `level_o`=0, `overflow_o`=0, next frame seq=0.
- `meas_done_i` and `wr_ack_i` in the same cycle on a full FIFO -> no overflow, `level_o` stays 4.
